// File: rtl/ov7670_pwr_seq.sv
// OV7670 power sequencer: steps xclk enable, PWDN, RESETB and SCCB config start
// with fixed dwell times, then reports ready or fault; orderly shutdown on enable=0.
module ov7670_pwr_seq #(
    parameter int T_CLK_CYC       = 64,
    parameter int T_PWDN_CYC      = 24000,
    parameter int T_SETTLE_CYC    = 24000,
    parameter int CFG_TIMEOUT_CYC = 2400000,
    parameter int CNT_W           = 22
) (
    input  logic       cam_clk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       cfg_done,
    input  logic       cfg_err,
    output logic       cam_clk_en,
    output logic       cam_pwdn,
    output logic       cam_rstn,
    output logic       cfg_start,
    output logic       ready,
    output logic       fault,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CLK_WAIT  = 3'd1,
        PWDN_WAIT = 3'd2,
        SETTLE    = 3'd3,
        CFG       = 3'd4,
        READY     = 3'd5,
        FAULT     = 3'd6,
        SHUTDOWN  = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] LD_CLK    = CNT_W'(T_CLK_CYC - 1);
    localparam logic [CNT_W-1:0] LD_PWDN   = CNT_W'(T_PWDN_CYC - 1);
    localparam logic [CNT_W-1:0] LD_SETTLE = CNT_W'(T_SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0] LD_CFG    = CNT_W'(CFG_TIMEOUT_CYC - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             cnt_zero;

    assign cnt_zero = (cnt == '0);
    assign state_o  = state;

    always_ff @(posedge cam_clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            cam_clk_en <= 1'b0;
            cam_pwdn   <= 1'b1;
            cam_rstn   <= 1'b0;
            cfg_start  <= 1'b0;
            ready      <= 1'b0;
            fault      <= 1'b0;
        end else begin
            cfg_start <= 1'b0;
            // Dropping enable overrides every other transition; xclk keeps
            // running through the shutdown dwell so the sensor sees clocks.
            if (!enable && state != IDLE && state != SHUTDOWN) begin
                state    <= SHUTDOWN;
                ready    <= 1'b0;
                cam_rstn <= 1'b0;
                cam_pwdn <= 1'b1;
                cnt      <= LD_CLK;
            end else begin
                case (state)
                    IDLE: begin
                        if (enable) begin
                            state      <= CLK_WAIT;
                            cam_clk_en <= 1'b1;
                            cnt        <= LD_CLK;
                        end
                    end
                    CLK_WAIT: begin
                        if (cnt_zero) begin
                            state    <= PWDN_WAIT;
                            cam_pwdn <= 1'b0;
                            cnt      <= LD_PWDN;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    PWDN_WAIT: begin
                        if (cnt_zero) begin
                            state    <= SETTLE;
                            cam_rstn <= 1'b1;
                            cnt      <= LD_SETTLE;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    SETTLE: begin
                        if (cnt_zero) begin
                            state     <= CFG;
                            cfg_start <= 1'b1;
                            cnt       <= LD_CFG;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    CFG: begin
                        // Error beats done; done beats the timeout.
                        if (cfg_err) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else if (cfg_done) begin
                            state <= READY;
                            ready <= 1'b1;
                        end else if (cnt_zero) begin
                            state <= FAULT;
                            fault <= 1'b1;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    READY: begin
                    end
                    FAULT: begin
                    end
                    SHUTDOWN: begin
                        if (cnt_zero) begin
                            state      <= IDLE;
                            cam_clk_en <= 1'b0;
                            fault      <= 1'b0;
                        end else begin
                            cnt <= cnt - CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ov7670_pwr_seq.sv
// Directed bench for ov7670_pwr_seq with short dwell times; edge numbers in
// the checks count rising edges from the one that samples enable=1.
module tb_ov7670_pwr_seq;

    logic       cam_clk = 1'b0;
    logic       resetn;
    logic       enable;
    logic       cfg_done;
    logic       cfg_err;
    logic       cam_clk_en;
    logic       cam_pwdn;
    logic       cam_rstn;
    logic       cfg_start;
    logic       ready;
    logic       fault;
    logic [2:0] state_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 cam_clk = ~cam_clk;

    ov7670_pwr_seq #(
        .T_CLK_CYC(4),
        .T_PWDN_CYC(8),
        .T_SETTLE_CYC(6),
        .CFG_TIMEOUT_CYC(20),
        .CNT_W(8)
    ) dut (
        .cam_clk(cam_clk),
        .resetn(resetn),
        .enable(enable),
        .cfg_done(cfg_done),
        .cfg_err(cfg_err),
        .cam_clk_en(cam_clk_en),
        .cam_pwdn(cam_pwdn),
        .cam_rstn(cam_rstn),
        .cfg_start(cfg_start),
        .ready(ready),
        .fault(fault),
        .state_o(state_o)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic chk_pins(input string tag, input int en, input int pd, input int rn,
                            input int cs, input int rd, input int fl, input int st);
        check({tag, ".cam_clk_en"}, int'(cam_clk_en), en);
        check({tag, ".cam_pwdn"},   int'(cam_pwdn),   pd);
        check({tag, ".cam_rstn"},   int'(cam_rstn),   rn);
        check({tag, ".cfg_start"},  int'(cfg_start),  cs);
        check({tag, ".ready"},      int'(ready),      rd);
        check({tag, ".fault"},      int'(fault),      fl);
        check({tag, ".state"},      int'(state_o),    st);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge cam_clk);
            #1;
        end
    endtask

    // Raise enable from IDLE and follow the sequence up to edge 19 (in CFG).
    task automatic seq_up(input string tag, input bit stray);
        enable = 1'b1;
        tick(1);
        chk_pins({tag, ".e0"}, 1, 1, 0, 0, 0, 0, 1);
        if (stray) begin
            cfg_done = 1'b1;
            cfg_err  = 1'b1;
            tick(1);
            cfg_done = 1'b0;
            cfg_err  = 1'b0;
            chk_pins({tag, ".stray_clkwait"}, 1, 1, 0, 0, 0, 0, 1);
            tick(2);
        end else begin
            tick(3);
        end
        check({tag, ".e3.cam_pwdn"}, int'(cam_pwdn), 1);
        tick(1);
        chk_pins({tag, ".e4"}, 1, 0, 0, 0, 0, 0, 2);
        tick(7);
        check({tag, ".e11.cam_rstn"}, int'(cam_rstn), 0);
        tick(1);
        chk_pins({tag, ".e12"}, 1, 0, 1, 0, 0, 0, 3);
        tick(5);
        check({tag, ".e17.cfg_start"}, int'(cfg_start), 0);
        tick(1);
        chk_pins({tag, ".e18"}, 1, 0, 1, 1, 0, 0, 4);
        tick(1);
        chk_pins({tag, ".e19"}, 1, 0, 1, 0, 0, 0, 4);
    endtask

    // From edge 19, pulse cfg_done sampled at edge 25.
    task automatic finish_ready(input string tag);
        tick(5);
        check({tag, ".e24.ready"}, int'(ready), 0);
        cfg_done = 1'b1;
        tick(1);
        cfg_done = 1'b0;
        chk_pins({tag, ".e25"}, 1, 0, 1, 0, 1, 0, 5);
        tick(3);
        chk_pins({tag, ".e28"}, 1, 0, 1, 0, 1, 0, 5);
    endtask

    task automatic shut_down(input string tag, input int was_fault);
        enable = 1'b0;
        tick(1);
        chk_pins({tag, ".sd0"}, 1, 1, 0, 0, 0, was_fault, 7);
        tick(3);
        chk_pins({tag, ".sd3"}, 1, 1, 0, 0, 0, was_fault, 7);
        tick(1);
        chk_pins({tag, ".sd4"}, 0, 1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn   = 1'b0;
        enable   = 1'b0;
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
        tick(2);
        chk_pins("rst", 0, 1, 0, 0, 0, 0, 0);
        @(negedge cam_clk);
        resetn = 1'b1;
        tick(2);
        chk_pins("idle", 0, 1, 0, 0, 0, 0, 0);

        // 1: nominal power-up
        seq_up("s1", 1'b0);
        finish_ready("s1");
        shut_down("s1", 0);

        // 2: configuration timeout, then shutdown from FAULT
        seq_up("s2", 1'b0);
        tick(18);
        chk_pins("s2.e37", 1, 0, 1, 0, 0, 0, 4);
        tick(1);
        chk_pins("s2.e38", 1, 0, 1, 0, 0, 1, 6);
        tick(7);
        chk_pins("s2.e45", 1, 0, 1, 0, 0, 1, 6);
        shut_down("s2", 1);

        // 3a: done and err together -> err wins
        seq_up("s3a", 1'b0);
        tick(1);
        cfg_done = 1'b1;
        cfg_err  = 1'b1;
        tick(1);
        cfg_done = 1'b0;
        cfg_err  = 1'b0;
        chk_pins("s3a.both", 1, 0, 1, 0, 0, 1, 6);
        tick(2);
        check("s3a.ready_held_low", int'(ready), 0);
        shut_down("s3a", 1);

        // 3b: done on the timeout cycle -> done wins
        seq_up("s3b", 1'b0);
        tick(18);
        chk_pins("s3b.e37", 1, 0, 1, 0, 0, 0, 4);
        cfg_done = 1'b1;
        tick(1);
        cfg_done = 1'b0;
        chk_pins("s3b.e38", 1, 0, 1, 0, 1, 0, 5);
        shut_down("s3b", 0);

        // 4: enable dropped in PWDN_WAIT, re-raised during SHUTDOWN
        enable = 1'b1;
        tick(1);
        chk_pins("s4.e0", 1, 1, 0, 0, 0, 0, 1);
        tick(7);
        chk_pins("s4.e7", 1, 0, 0, 0, 0, 0, 2);
        enable = 1'b0;
        tick(1);
        chk_pins("s4.e8", 1, 1, 0, 0, 0, 0, 7);
        enable = 1'b1;
        tick(3);
        chk_pins("s4.e11", 1, 1, 0, 0, 0, 0, 7);
        tick(1);
        chk_pins("s4.e12", 0, 1, 0, 0, 0, 0, 0);
        tick(1);
        chk_pins("s4.e13", 1, 1, 0, 0, 0, 0, 1);

        // 5: asynchronous reset while in SETTLE, then full repeat
        tick(14);
        chk_pins("s5.settle", 1, 0, 1, 0, 0, 0, 3);
        #2;
        resetn = 1'b0;
        #1;
        chk_pins("s5.async", 0, 1, 0, 0, 0, 0, 0);
        tick(2);
        chk_pins("s5.held", 0, 1, 0, 0, 0, 0, 0);
        @(negedge cam_clk);
        resetn = 1'b1;
        seq_up("s5", 1'b0);
        finish_ready("s5");
        shut_down("s5", 0);

        // 6: stray handshake pulses outside CFG
        cfg_done = 1'b1;
        tick(1);
        cfg_done = 1'b0;
        chk_pins("s6.idle_done", 0, 1, 0, 0, 0, 0, 0);
        cfg_err = 1'b1;
        tick(1);
        cfg_err = 1'b0;
        chk_pins("s6.idle_err", 0, 1, 0, 0, 0, 0, 0);
        seq_up("s6", 1'b1);
        finish_ready("s6");
        cfg_err = 1'b1;
        tick(1);
        cfg_err = 1'b0;
        chk_pins("s6.ready_err", 1, 0, 1, 0, 1, 0, 5);
        cfg_done = 1'b1;
        tick(1);
        cfg_done = 1'b0;
        chk_pins("s6.ready_done", 1, 0, 1, 0, 1, 0, 5);
        shut_down("s6", 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
